// File: rtl/dds_adc_mac.sv
// dds_adc_mac: pipelined signed DDS x ADC multiply feeding an integrate-and-dump
// accumulator over a programmable window of valid samples.
// Pipeline: stage 1 registers a/y, stage 2 registers the full product,
// stage 3 accumulates and dumps a scaled, registered result with a one-cycle strobe.
// Build option: define DDS_ADC_MAC_SAT_EN to clamp out-of-range dumps to the
// signed OUT_WIDTH limits; otherwise the low OUT_WIDTH bits are kept (wrap).
// The sticky overflow flag behaves identically in both builds.

`default_nettype none

module dds_adc_mac #(
    parameter int A_WIDTH   = 32,
    parameter int Y_WIDTH   = 12,
    parameter int CNT_WIDTH = 24,
    parameter int ACC_WIDTH = 64,
    parameter int OUT_WIDTH = 32,
    parameter int OUT_SHIFT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 cont,
    input  logic [CNT_WIDTH-1:0] win_len,
    input  logic                 in_valid,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [Y_WIDTH-1:0]   y,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 busy,
    output logic                 overflow
);

    localparam int P_WIDTH = A_WIDTH + Y_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                       state_r;
    state_t                       state_s;
    logic signed [A_WIDTH-1:0]    a_r;
    logic signed [Y_WIDTH-1:0]    y_r;
    logic                         v1_r;
    logic signed [P_WIDTH-1:0]    prod_r;
    logic signed [P_WIDTH-1:0]    prod_s;
    logic                         v2_r;
    logic signed [ACC_WIDTH-1:0]  acc_r;
    logic signed [ACC_WIDTH-1:0]  prod_ext_s;
    logic signed [ACC_WIDTH-1:0]  acc_sum_s;
    logic signed [ACC_WIDTH-1:0]  acc_shift_s;
    logic [CNT_WIDTH-1:0]         cnt_r;
    logic [CNT_WIDTH-1:0]         len_r;
    logic [CNT_WIDTH-1:0]         len_s;
    logic                         cont_r;
    logic                         start_s;
    logic                         dump_s;
    logic                         end_s;
    logic                         accept_s;
    logic                         ovf_s;
    logic [OUT_WIDTH-1:0]         res_s;
    logic                         out_valid_r;
    logic [OUT_WIDTH-1:0]         out_data_r;
    logic                         busy_r;
    logic                         overflow_r;

    // True when the shifted sum does not fit in a signed OUT_WIDTH value:
    // all bits from the OUT_WIDTH sign bit upward must agree.
    function automatic logic out_of_range(input logic signed [ACC_WIDTH-1:0] v);
        logic [ACC_WIDTH-OUT_WIDTH:0] hi;
        hi = v[ACC_WIDTH-1:OUT_WIDTH-1];
        return !((&hi) || (~|hi));
    endfunction

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign overflow  = overflow_r;

    // Control decode, full-width product, accumulate/shift datapath.
    always_comb begin
        start_s    = (state_r == IDLE) && start && !stop;
        len_s      = (win_len == CNT_ZERO) ? CNT_ONE : win_len;
        dump_s     = (state_r == RUN) && v2_r && !stop && (cnt_r == (len_r - CNT_ONE));
        // A window ends on abort or on a dump that does not chain into another window.
        end_s      = (state_r == RUN) && (stop || (dump_s && !cont_r));
        accept_s   = (state_r == RUN) && in_valid && !end_s;
        prod_s     = $signed({{Y_WIDTH{a_r[A_WIDTH-1]}}, a_r}) *
                     $signed({{A_WIDTH{y_r[Y_WIDTH-1]}}, y_r});
        prod_ext_s = {{(ACC_WIDTH-P_WIDTH){prod_r[P_WIDTH-1]}}, prod_r};
        acc_sum_s  = acc_r + prod_ext_s;
        acc_shift_s = acc_sum_s >>> OUT_SHIFT;
        ovf_s      = out_of_range(acc_shift_s);
`ifdef DDS_ADC_MAC_SAT_EN
        if (ovf_s) begin
            res_s = acc_shift_s[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                             : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else begin
            res_s = acc_shift_s[OUT_WIDTH-1:0];
        end
`else
        res_s = acc_shift_s[OUT_WIDTH-1:0];
`endif
    end

    // Next-state logic for the IDLE/RUN window controller.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (end_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
        end
    end

    // Stage 1: operand capture; only samples seen in RUN are tagged valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r  <= '0;
            y_r  <= '0;
            v1_r <= 1'b0;
        end else begin
            a_r  <= a;
            y_r  <= y;
            v1_r <= accept_s;
        end
    end

    // Stage 2: full-precision product; in-flight samples die when a window ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_r <= '0;
            v2_r   <= 1'b0;
        end else begin
            prod_r <= prod_s;
            v2_r   <= v1_r && !end_s;
        end
    end

    // Stage 3: window bookkeeping, accumulate, dump and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r       <= '0;
            cnt_r       <= '0;
            len_r       <= '0;
            cont_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            overflow_r  <= 1'b0;
        end else begin
            out_valid_r <= dump_s;
            if (start_s) begin
                acc_r      <= '0;
                cnt_r      <= '0;
                len_r      <= len_s;
                cont_r     <= cont;
                overflow_r <= 1'b0;
            end else if (state_r == RUN) begin
                if (stop) begin
                    acc_r <= '0;
                    cnt_r <= '0;
                end else if (dump_s) begin
                    acc_r      <= '0;
                    cnt_r      <= '0;
                    cont_r     <= cont;
                    out_data_r <= res_s;
                    overflow_r <= overflow_r | ovf_s;
                end else if (v2_r) begin
                    acc_r <= acc_sum_s;
                    cnt_r <= cnt_r + CNT_ONE;
                end else begin
                    acc_r <= acc_r;
                end
            end else begin
                acc_r <= acc_r;
            end
        end
    end

endmodule

`default_nettype wire
